// File: rtl/conv_engine_pkg.sv
// Shared types and arithmetic helpers for the convolution layer engine.
// Contents: state_t (engine FSM states), acc_width() (accumulator sizing),
// and quantise() (rescale plus saturate of a lane sum).
// Build option: CONV_ENGINE_RELU_EN, when defined, makes quantise() clamp
// negative sums to zero (ReLU) before positive saturation.
package conv_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product width plus enough guard bits to sum acc_len products without wrap
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned acc_len);
        return 2 * width + $clog2(acc_len);
    endfunction

    // Arithmetic right shift to ofm scale, then saturate to a signed width-bit range
    function automatic logic signed [63:0] quantise(input logic signed [63:0] sum,
                                                    input int unsigned       shift,
                                                    input int unsigned       width);
        logic signed [63:0] q;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        q     = sum >>> shift;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
`ifdef CONV_ENGINE_RELU_EN
        if (sum < 64'sd0) begin
            q = 64'sd0;
        end
`endif
        if (q > max_v) begin
            q = max_v;
        end else if (q < min_v) begin
            q = min_v;
        end
        return q;
    endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// Bus bundle between the convolution engine and its surroundings.
// slave  : engine side (consumes start/pixels/weights/bias/feedback, drives
//          weight address, busy, ofm stream and done).
// master : environment side, the mirror image.
interface conv_layer_engine_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DSP_NO = 32,
    parameter int unsigned ADDR_W = 7
);
    logic                               start;
    logic                               pix_valid;
    logic [WIDTH-1:0]                   ifm;
    logic [DSP_NO-1:0][WIDTH-1:0]       kernels;
    logic [DSP_NO-1:0][2*WIDTH-1:0]     bias;
    logic                               ram_feedback;
    logic [ADDR_W-1:0]                  wrom_addr;
    logic                               busy;
    logic                               ofm_valid;
    logic [DSP_NO-1:0][WIDTH-1:0]       ofm;
    logic                               done;

    modport slave (
        input  start, pix_valid, ifm, kernels, bias, ram_feedback,
        output wrom_addr, busy, ofm_valid, ofm, done
    );

    modport master (
        output start, pix_valid, ifm, kernels, bias, ram_feedback,
        input  wrom_addr, busy, ofm_valid, ofm, done
    );
endinterface

// File: rtl/conv_mac_lane.sv
// One output-channel MAC lane: S1 registers ifm*kernel, S2 accumulates and,
// on the last beat of a pixel, adds bias and quantises into the ofm register.
// Ports: clk, rst (sync, active high); en = beat accepted this cycle;
// s1_valid/s1_first/s1_last = tags travelling alongside the S1 product;
// ifm, kernel, bias = operands; ofm = registered quantised result.
// Build option: CONV_ENGINE_RELU_EN selects ReLU clamping inside quantise().
module conv_mac_lane
    import conv_engine_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ACC_W      = 39,
    parameter int unsigned FRAC_SHIFT = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      s1_valid,
    input  logic                      s1_first,
    input  logic                      s1_last,
    input  logic signed [WIDTH-1:0]   ifm,
    input  logic signed [WIDTH-1:0]   kernel,
    input  logic signed [2*WIDTH-1:0] bias,
    output logic [WIDTH-1:0]          ofm
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned SUM_W = ACC_W + 1;

    logic signed [PW-1:0]    prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_base_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [WIDTH-1:0]        ofm_q, ofm_d;

    // S1 product capture and S2 accumulate / bias / quantise
    always_comb begin
        prod_d     = prod_q;
        acc_d      = acc_q;
        ofm_d      = ofm_q;
        acc_base_c = acc_q;
        sum_c      = '0;
        if (en) begin
            prod_d = PW'(ifm) * PW'(kernel);
        end
        if (s1_valid) begin
            if (s1_first) begin
                acc_base_c = '0;
            end
            acc_d = acc_base_c + ACC_W'(prod_q);
            if (s1_last) begin
                sum_c = SUM_W'(acc_d) + SUM_W'(bias);
                ofm_d = WIDTH'(quantise(64'(sum_c), FRAC_SHIFT, WIDTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            ofm_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            ofm_q  <= ofm_d;
        end
    end

    assign ofm = ofm_q;

endmodule

// File: rtl/conv_layer_engine.sv
// Generic KxK / 1x1 convolution layer engine with DSP_NO parallel MAC lanes.
// Holds the layer FSM (IDLE/RUN/DRAIN/DONE), beat and pixel counters, the
// shared S1 pipeline tags, and the start/busy/done handshake.
// Ports: clk, rst (sync, active high); bus (slave modport): start, pix_valid,
// ifm, kernels, bias, ram_feedback in; wrom_addr, busy, ofm_valid, ofm, done out.
// Build option: CONV_ENGINE_RELU_EN selects ReLU output clamping in the lanes.
module conv_layer_engine
    import conv_engine_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DSP_NO     = 32,
    parameter int unsigned CHIN       = 128,
    parameter int unsigned KERNEL_DIM = 1,
    parameter int unsigned WOUT       = 32,
    parameter int unsigned FRAC_SHIFT = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_layer_engine_if.slave   bus
);
    localparam int unsigned ACC_LEN = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int unsigned ACC_W   = acc_width(WIDTH, ACC_LEN);
    localparam int unsigned ADDR_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int unsigned NPIX    = WOUT * WOUT;
    localparam int unsigned PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic                s1_valid_q, s1_valid_d;
    logic                s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d;
    logic                ofm_valid_q, ofm_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                first_c, last_c, pix_last_c;
    logic [DSP_NO-1:0][WIDTH-1:0] ofm_w;

    // Next-state, counters and pipeline tags
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        s1_valid_d  = 1'b0;
        s1_first_d  = 1'b0;
        s1_last_d   = 1'b0;
        ofm_valid_d = s1_valid_q && s1_last_q;
        first_c     = (acc_cnt_q == '0);
        last_c      = (acc_cnt_q == ADDR_W'(ACC_LEN - 1));
        pix_last_c  = (pix_cnt_q == PIX_W'(NPIX - 1));
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.pix_valid) begin
                    s1_valid_d = 1'b1;
                    s1_first_d = first_c;
                    s1_last_d  = last_c;
                    if (last_c) begin
                        acc_cnt_d = '0;
                        if (pix_last_c) begin
                            pix_cnt_d = '0;
                            state_d   = DRAIN;
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end else begin
                        acc_cnt_d = acc_cnt_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Final pulse is the one with no further beat behind it in S1
                if (ofm_valid_q && !s1_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ram_feedback) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            ofm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            ofm_valid_q <= ofm_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Parallel output-channel lanes share the tags and the ifm beat
    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        conv_mac_lane #(
            .WIDTH      (WIDTH),
            .ACC_W      (ACC_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (s1_valid_d),
            .s1_valid (s1_valid_q),
            .s1_first (s1_first_q),
            .s1_last  (s1_last_q),
            .ifm      (bus.ifm),
            .kernel   (bus.kernels[i]),
            .bias     (bus.bias[i]),
            .ofm      (ofm_w[i])
        );
    end

    assign bus.wrom_addr = acc_cnt_q;
    assign bus.busy      = busy_q;
    assign bus.ofm_valid = ofm_valid_q;
    assign bus.ofm       = ofm_w;
    assign bus.done      = done_q;

endmodule

// File: doc/conv_layer_engine.md
Name: conv_layer_engine

Overview:
- Parametrised successor of the fixed per-layer squeeze/expand cores: one generic KxK / 1x1 convolution engine with DSP_NO parallel output-channel MAC lanes.
- Streams one input pixel per accepted beat, walks the weight ROM address and accumulates KERNEL_DIM²·CHIN beats per output pixel. Adds bias, then applies ReLU or signed clamp, rescales and saturates.
- Start/busy/done handshake, a pixel-valid stall input, and a done handshake released by the downstream RAM.
- Replaces per-layer fireN_* copies. Weight ROM and bias modules are instantiated outside the engine and connected through ports.

Parameters:
- WIDTH, 16, pixel/weight/ofm width, signed fixed point.
- DSP_NO, 32, output channels computed in parallel (MAC lanes).
- CHIN, 128, input channels.
- KERNEL_DIM, 1, kernel side (1 or 3).
- WOUT, 32, output feature-map side; WOUT² output pixels per layer.
- FRAC_SHIFT, 14, right shift from product scale to ofm scale.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch layer; sampled in IDLE only.
- pix_valid  in  1  ifm beat valid; low = stall.
- ifm  in  WIDTH  signed input pixel.
- kernels  in  DSP_NO x WIDTH  weight ROM data for the current wrom_addr (combinational ROM).
- bias  in  DSP_NO x 2*WIDTH  per-lane bias, product scale.
- ram_feedback  in  1  downstream RAM acknowledges layer completion.
- wrom_addr  out  clog2(KERNEL_DIM²·CHIN)  weight ROM address.
- busy  out  1  high from the edge after start until done is reached.
- ofm_valid  out  1  one-cycle pulse per output pixel.
- ofm  out  DSP_NO x WIDTH  output channels, registered.
- done  out  1  layer finished, held until ram_feedback.

Behaviour:
- Reset (clk edge with rst=1, also mid-operation): state IDLE; all counters 0; accumulators 0; pipeline tags 0; busy=0, ofm_valid=0, done=0, wrom_addr=0, ofm=all 0.
- ACC_LEN = KERNEL_DIM²·CHIN.
- ACC_W = 2*WIDTH + clog2(ACC_LEN). The product is 2*WIDTH signed; the accumulator is ACC_W signed with no wrap.
- FSM states:
  - IDLE: start=1 -> RUN, busy=1.
  - RUN: pixels accepted until WOUT² pixels have been fully issued -> DRAIN.
  - DRAIN: wait for the last ofm_valid -> DONE.
  - DONE: done=1 until ram_feedback=1 -> IDLE (done and busy drop on that edge).
- start in any state other than IDLE is ignored.
- A beat is accepted when state=RUN and pix_valid=1. On acceptance:
  - acc_cnt increments, wrapping ACC_LEN-1 -> 0.
  - On the wrap, pix_cnt increments.
  - wrom_addr = acc_cnt, so kernels belong to the beat being accepted.
  - Beats with pix_valid=0 change no state.
- Lane pipeline:
  - S1 registers ifm*kernels[i] together with tags first (acc_cnt==0), last (acc_cnt==ACC_LEN-1) and valid.
  - S2 computes acc <= (first ? 0 : acc) + prod.
  - When a valid S1 entry is tagged last, S2 computes sum = acc_next + sign-extended bias[i]. The quantised sum goes to ofm[i] and ofm_valid=1 on that same edge.
- Latency: ofm_valid is high during cycle N+2 when the last beat of a pixel is accepted at edge N.
- Back-to-back pixels are supported with no bubble.
- Quantise: q = sum >>> FRAC_SHIFT (arithmetic), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The Optional Feature clamps negatives.
- Exactly WOUT² ofm_valid pulses per layer. Pulses never occur in IDLE or DONE.
- If ram_feedback=1 arrives in the same cycle the last ofm_valid completes: DONE is entered and done asserts for at least one cycle. ram_feedback is then acted on from DONE only.

Optional Feature:
- Macro: CONV_ENGINE_RELU_EN.
- Defined: any sum < 0 gives ofm=0, then positive saturation to 2^(WIDTH-1)-1.
- Undefined: signed output with symmetric saturation as above.

Decomposition:
- Package conv_engine_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN, DONE};
  - function acc_width(width, acc_len);
  - function quantise(sum, shift, width) implementing shift+saturate, with the ReLU branch under the macro.
- One sub-module, conv_mac_lane: S1 multiply, S2 accumulate, bias add, quantise; instantiated DSP_NO times in a generate loop.
- The top holds the FSM, counters and handshakes.

Test Plan (DSP_NO=2, CHIN=4, KERNEL_DIM=1, WOUT=2, WIDTH=16, FRAC_SHIFT=14 unless stated):
- Basic: start, then 16 continuous beats with ifm=4096, kernels=8192, bias=0 -> 4 ofm_valid pulses of ofm=8192 each. First pulse 2 cycles after the 4th beat. Then done=1.
- Bias: as Basic with bias[1]=2^28 -> ofm[0]=8192, ofm[1]=8192+16384=24576.
- Saturation: ifm=kernels=16384 -> sum 2^30 >> 14 = 65536 -> ofm=32767. With kernels=-16384: ofm=0 if CONV_ENGINE_RELU_EN, else -32768.
- Stall: pix_valid toggling 1,0,0,1 through the layer -> identical ofm values and 4 pulses; wrom_addr holds during stalls.
- Reset mid-run: rst after 6 beats -> busy=0, ofm=0, wrom_addr=0 next cycle. A fresh start then reproduces the Basic result.
- Handshake: done held 10 cycles with ram_feedback=0; start pulsed while busy is ignored. ram_feedback=1 -> done=0 and IDLE on the next edge.
